mem_access_ctrl: RTL

- Sequences all accesses to the 512-word unified RAM (9-bit address) and arbitrates between two requesters: instruction fetch (IF) and data load/store (D).
- Owns the address, write-data and strobe registers that drive the RAM, and returns read data with a single-cycle ack.
- Sits between the control unit's fetch/execute logic and the RAM.

---
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences every access to the unified RAM and arbitrates
// between the instruction-fetch requester (IF, read only) and the data
// requester (D, load/store).
//
// State table:
//   state | meaning
//   IDLE  | sample requests, latch address/data of the winner
//   ADDR  | ram_addr valid, one-cycle ram_we or ram_re strobe
//   RWAIT | wait RAM_LAT cycles for read data, capture on the last one
//   DONE  | one-cycle ack to the granted requester
//
// Ports:
//   clock, clear              clock and asynchronous active-high reset
//   if_req/if_addr/if_ack     fetch request interface
//   d_req/d_we/d_addr/d_wdata/d_ack  data request interface
//   rdata                     read data, valid with the ack, held between reads
//   ram_addr/ram_wdata/ram_we/ram_re/ram_rdata  RAM interface
//   busy                      high outside IDLE
//   grant                     owner of the current/last access (0 = IF, 1 = D)
module mem_access_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              grant
);

   localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

   typedef enum logic [1:0] {IDLE, ADDR, RWAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              take_d;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         grant_q      <= 1'b0;
         // last owner starts as D so IF wins the first contention
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      take_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               // on contention, D wins only if IF owned the previous access
               take_d       = d_req && (!if_req || !last_grant_q);
               grant_d      = take_d;
               last_grant_d = take_d;
               state_d      = ADDR;
               if (take_d) begin
                  addr_d = d_addr;
                  wr_d   = d_we;
                  if (d_we) wdata_d = d_wdata;
               end else begin
                  addr_d = if_addr;
                  wr_d   = 1'b0;
               end
            end
         end
         ADDR: begin
            if (wr_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = CNT_W'(RAM_LAT);
               state_d = RWAIT;
            end
         end
         RWAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               rdata_d = ram_rdata;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_we    = (state_q == ADDR) &&  wr_q;
   assign ram_re    = (state_q == ADDR) && !wr_q;
   assign if_ack    = (state_q == DONE) && !grant_q;
   assign d_ack     = (state_q == DONE) &&  grant_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != IDLE);
   assign grant     = grant_q;

endmodule
